param_code_lock: RTL and testbench

//  Parametrised keypad combination lock: user-programmable N-digit code, full-length compare
//  (no early abort), failed-attempt counter, timed lockout, timed auto-relock, sticky alarm.

---
 rtl/param_code_lock.sv | 178 +++++++++++++++++
 tb/tb_param_code_lock.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/param_code_lock.sv
// ============================================================================
// Module      : param_code_lock
// Description : Programmable N-digit keypad lock with a full-length compare,
//               a failure counter, a timed lockout, a timed auto-relock and a
//               sticky alarm.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module param_code_lock #(
    parameter int DIGITS      = 8,
    parameter int DIGIT_W     = 4,
    parameter int MAX_FAILS   = 3,
    parameter int LOCKOUT_CYC = 500,
    parameter int OPEN_CYC    = 1000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              key_valid,
    input  logic [DIGIT_W-1:0]                key_val,
    input  logic                              key_enter,
    input  logic                              key_clear,
    output logic [2:0]                        state,
    output logic [$clog2(DIGITS+1)-1:0]       pos,
    output logic [DIGITS*DIGIT_W-1:0]         code_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt,
    output logic                              unlocked,
    output logic                              alarm,
    output logic                              locked_out
);

    localparam int PW   = $clog2(DIGITS+1);
    localparam int FW   = $clog2(MAX_FAILS+1);
    localparam int TMAX = (LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC;
    localparam int TW   = $clog2(TMAX+1);
    localparam int CW   = DIGITS*DIGIT_W;

    typedef enum logic [2:0] {
        PROG    = 3'd0,
        IDLE    = 3'd1,
        ENTRY   = 3'd2,
        OPEN    = 3'd3,
        LOCKOUT = 3'd4,
        ALARM   = 3'd5
    } state_t;

    state_t               cur_state;
    logic [TW-1:0]        timer;
    logic                 mismatch;
    logic [DIGIT_W-1:0]   exp_digit;
    logic                 attempt_bad;

    assign state = cur_state;

    // Stored digit addressed by pos, first digit living in the MSBs.
    always_comb begin
        exp_digit = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (pos == PW'(i))
                exp_digit = code_out[(DIGITS-1-i)*DIGIT_W +: DIGIT_W];
        end
    end

    assign attempt_bad = mismatch | (key_val != exp_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state  <= PROG;
            pos        <= '0;
            code_out   <= '0;
            fail_cnt   <= '0;
            timer      <= '0;
            mismatch   <= 1'b0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            case (cur_state)
                PROG: begin
                    if (key_clear) begin
                        code_out <= '0;
                        pos      <= '0;
                    end else if (key_enter) begin
                        if (pos == PW'(DIGITS)) begin
                            cur_state <= IDLE;
                            pos       <= '0;
                            timer     <= '0;
                        end
                    end else if (key_valid) begin
                        code_out <= {code_out[CW-DIGIT_W-1:0], key_val};
                        if (pos != PW'(DIGITS))
                            pos <= pos + PW'(1);
                    end
                end

                IDLE: begin
                    if (!key_clear && key_enter) begin
                        cur_state <= ENTRY;
                        pos       <= '0;
                        mismatch  <= 1'b0;
                        timer     <= '0;
                    end
                end

                ENTRY: begin
                    if (key_clear) begin
                        cur_state <= IDLE;
                        pos       <= '0;
                        timer     <= '0;
                    end else if (key_enter) begin
                        pos      <= '0;
                        mismatch <= 1'b0;
                    end else if (key_valid) begin
                        mismatch <= attempt_bad;
                        pos      <= pos + PW'(1);
                        // The verdict is withheld until the final digit arrives.
                        if (pos == PW'(DIGITS-1)) begin
                            timer <= '0;
                            if (!attempt_bad) begin
                                cur_state <= OPEN;
                                fail_cnt  <= '0;
                                unlocked  <= 1'b1;
                            end else if (fail_cnt == FW'(MAX_FAILS-1)) begin
                                cur_state <= ALARM;
                                fail_cnt  <= FW'(MAX_FAILS);
                                alarm     <= 1'b1;
                            end else begin
                                cur_state  <= LOCKOUT;
                                fail_cnt   <= fail_cnt + FW'(1);
                                locked_out <= 1'b1;
                            end
                        end
                    end
                end

                OPEN: begin
                    if (key_clear) begin
                        cur_state <= PROG;
                        code_out  <= '0;
                        pos       <= '0;
                        timer     <= '0;
                        unlocked  <= 1'b0;
                    end else if (key_enter || timer == TW'(OPEN_CYC-1)) begin
                        cur_state <= IDLE;
                        timer     <= '0;
                        unlocked  <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                LOCKOUT: begin
                    if (timer == TW'(LOCKOUT_CYC-1)) begin
                        cur_state  <= IDLE;
                        timer      <= '0;
                        locked_out <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                ALARM: begin
                end

                default: begin
                    cur_state  <= ALARM;
                    timer      <= '0;
                    unlocked   <= 1'b0;
                    locked_out <= 1'b0;
                    alarm      <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_param_code_lock.sv
// ============================================================================
// Module      : tb_param_code_lock
// Description : Directed self-checking bench for param_code_lock.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_param_code_lock;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_val = 4'd0;
    logic        key_enter = 1'b0;
    logic        key_clear = 1'b0;
    logic [2:0]  state;
    logic [2:0]  pos;
    logic [15:0] code_out;
    logic [1:0]  fail_cnt;
    logic        unlocked;
    logic        alarm;
    logic        locked_out;

    int n_checks = 0;
    int n_errors = 0;
    int cnt;

    localparam logic [2:0] S_PROG = 3'd0, S_IDLE = 3'd1, S_ENTRY = 3'd2,
                           S_OPEN = 3'd3, S_LOCK = 3'd4, S_ALARM = 3'd5;

    param_code_lock #(
        .DIGITS(4), .DIGIT_W(4), .MAX_FAILS(3), .LOCKOUT_CYC(10), .OPEN_CYC(20)
    ) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_val(key_val),
        .key_enter(key_enter), .key_clear(key_clear), .state(state), .pos(pos),
        .code_out(code_out), .fail_cnt(fail_cnt), .unlocked(unlocked),
        .alarm(alarm), .locked_out(locked_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        key_valid = 1'b1;
        key_val   = d;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic enter();
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic clear();
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
    endtask

    task automatic attempt(input logic [15:0] c);
        enter();
        key(c[15:12]); key(c[11:8]); key(c[7:4]); key(c[3:0]);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (state != S_IDLE && n < 50) begin
            n++;
            tick();
        end
        check_eq(tag, state, S_IDLE);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        // 1: reset values and programming
        tick(); tick();
        check_eq("rst_state", state, S_PROG);
        check_eq("rst_code", code_out, 16'h0);
        check_eq("rst_pos", pos, 0);
        check_eq("rst_flags", {unlocked, alarm, locked_out, fail_cnt}, 0);
        rst = 1'b0;
        key(1); key(2); key(3);
        check_eq("prog_pos3", pos, 3);
        enter();
        check_eq("prog_early_enter", state, S_PROG);
        key(4);
        check_eq("prog_pos_full", pos, 4);
        enter();
        check_eq("prog_to_idle", state, S_IDLE);
        check_eq("prog_code", code_out, 16'h1234);
        check_eq("prog_pos0", pos, 0);

        // 2: five digits keep the last four, open window is 20 cycles
        rst = 1'b1;
        #2;
        check_eq("async_rst_code", code_out, 16'h0);
        tick();
        rst = 1'b0;
        key(9); key(1); key(2); key(3); key(4);
        check_eq("prog5_pos", pos, 4);
        enter();
        check_eq("prog5_code", code_out, 16'h1234);
        enter();
        check_eq("entry_start", state, S_ENTRY);
        key(1); key(2); key(3);
        check_eq("entry_pos3", pos, 3);
        key(4);
        check_eq("open_state", state, S_OPEN);
        cnt = 0;
        while (unlocked && cnt < 100) begin
            cnt++;
            tick();
        end
        check_eq("open_cycles", cnt, 20);
        check_eq("open_relock", state, S_IDLE);

        // 3: wrong digit mid-code, decision only at the end, lockout length
        enter();
        key(1); key(9); key(3);
        check_eq("bad_still_entry", state, S_ENTRY);
        check_eq("bad_pos3", pos, 3);
        key(4);
        check_eq("lockout_state", state, S_LOCK);
        check_eq("lockout_fail1", fail_cnt, 1);
        key_valid = 1'b1; key_val = 4'd1; key_enter = 1'b1; key_clear = 1'b1;
        cnt = 0;
        while (locked_out && cnt < 100) begin
            cnt++;
            tick();
        end
        key_valid = 1'b0; key_enter = 1'b0; key_clear = 1'b0;
        check_eq("lockout_cycles", cnt, 10);
        check_eq("lockout_exit", state, S_IDLE);
        check_eq("lockout_code_kept", code_out, 16'h1234);

        // 5: clear beats valid, enter restarts the attempt
        enter();
        key(1); key(2);
        check_eq("abort_pos2", pos, 2);
        key_clear = 1'b1; key_valid = 1'b1; key_val = 4'd3;
        tick();
        key_clear = 1'b0; key_valid = 1'b0;
        check_eq("abort_idle", state, S_IDLE);
        check_eq("abort_fail_kept", fail_cnt, 1);
        enter();
        key(1); key(2); key(3);
        enter();
        check_eq("restart_pos0", pos, 0);
        check_eq("restart_state", state, S_ENTRY);
        key(1); key(2); key(3); key(4);
        check_eq("restart_open", state, S_OPEN);
        check_eq("open_fail_clr", fail_cnt, 0);

        // 6: enter relocks, clear in OPEN reprograms
        enter();
        check_eq("open_enter_idle", state, S_IDLE);
        check_eq("open_enter_unl", unlocked, 1'b0);
        attempt(16'h1234);
        check_eq("reopen", state, S_OPEN);
        clear();
        check_eq("open_clear_prog", state, S_PROG);
        check_eq("open_clear_code", code_out, 16'h0);
        check_eq("open_clear_pos", pos, 0);

        // 4: three failures -> sticky alarm, async reset out of it
        key(1); key(2); key(3); key(4);
        enter();
        attempt(16'h1111);
        check_eq("fail1", fail_cnt, 1);
        wait_idle("fail1_idle");
        attempt(16'h4321);
        check_eq("fail2", fail_cnt, 2);
        wait_idle("fail2_idle");
        attempt(16'h1235);
        check_eq("alarm_state", state, S_ALARM);
        check_eq("alarm_flag", alarm, 1'b1);
        check_eq("alarm_fail3", fail_cnt, 3);
        attempt(16'h1234);
        check_eq("alarm_sticky", state, S_ALARM);
        check_eq("alarm_no_open", unlocked, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("alarm_rst_state", state, S_PROG);
        check_eq("alarm_rst_code", code_out, 16'h0);
        check_eq("alarm_rst_flag", alarm, 1'b0);
        tick();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
